// File: rtl/icache_direct_ctrl.sv
// Direct-mapped read-only instruction cache controller with a 4-word line refill
// over a one-word request/valid handshake to backing memory.
module icache_direct_ctrl #(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int unsigned NumLines = 1 << INDEX_BITS;
  localparam int unsigned NumWords = NumLines * 4;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                state_q;
  logic [TAG_BITS-1:0]   tag_l_q;
  logic [INDEX_BITS-1:0] index_l_q;
  logic [1:0]            offset_l_q;
  logic [1:0]            cnt_q;
  logic [NumLines-1:0]   valid_q;
  logic                  mem_req_q;
  logic [15:0]           mem_addr_q;

  logic [TAG_BITS-1:0]   tag_mem  [NumLines];
  logic [15:0]           data_mem [NumWords];

  logic [TAG_BITS-1:0]   a_tag;
  logic [INDEX_BITS-1:0] a_index;
  logic [1:0]            a_offset;

  logic idle;
  logic err_c;
  logic lookup;
  logic hit;
  logic miss;
  logic fill_we;
  logic fill_last;

  assign a_offset = Addr[2:1];
  assign a_index  = Addr[2+INDEX_BITS:3];
  assign a_tag    = Addr[15:3+INDEX_BITS];

  // Gating with rst keeps every output at 0 while reset is held.
  assign idle      = (state_q == StIdle) && !rst;
  assign err_c     = idle && (Wr || (Rd && Addr[0]));
  assign lookup    = idle && Rd && !err_c;
  assign hit       = lookup && valid_q[a_index] && (tag_mem[a_index] == a_tag);
  assign miss      = lookup && !hit;
  assign fill_we   = (state_q == StWait) && mem_valid;
  assign fill_last = fill_we && (cnt_q == 2'd3);

  assign err      = err_c;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    DataOut  = 16'h0000;
    Done     = 1'b0;
    CacheHit = 1'b0;
    Stall    = 1'b0;
    if (hit) begin
      Done     = 1'b1;
      CacheHit = 1'b1;
      DataOut  = data_mem[{a_index, a_offset}];
    end else if (miss) begin
      Stall = 1'b1;
    end else if (state_q == StReq || state_q == StWait) begin
      Stall = 1'b1;
    end else if (state_q == StDone) begin
      Done    = 1'b1;
      DataOut = data_mem[{index_l_q, offset_l_q}];
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{index_l_q, cnt_q}] <= mem_rdata;
    end
    if (fill_last) begin
      tag_mem[index_l_q] <= tag_l_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tag_l_q    <= '0;
      index_l_q  <= '0;
      offset_l_q <= 2'd0;
      cnt_q      <= 2'd0;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (miss) begin
            tag_l_q          <= a_tag;
            index_l_q        <= a_index;
            offset_l_q       <= a_offset;
            cnt_q            <= 2'd0;
            valid_q[a_index] <= 1'b0;
            mem_req_q        <= 1'b1;
            mem_addr_q       <= {a_tag, a_index, 2'b00, 1'b0};
            state_q          <= StReq;
          end
        end
        StReq: begin
          mem_req_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          if (mem_valid) begin
            if (cnt_q == 2'd3) begin
              valid_q[index_l_q] <= 1'b1;
              state_q            <= StDone;
            end else begin
              cnt_q      <= cnt_q + 2'd1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {tag_l_q, index_l_q, cnt_q + 2'd1, 1'b0};
              state_q    <= StReq;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct_ctrl.sv
// Randomized self-checking bench for icache_direct_ctrl against a behavioural
// cache model and a backing-memory responder with configurable latency.
module tb_icache_direct_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  icache_direct_ctrl #(
    .INDEX_BITS(5),
    .TAG_BITS  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .Rd       (Rd),
    .Wr       (Wr),
    .DataOut  (DataOut),
    .Done     (Done),
    .Stall    (Stall),
    .CacheHit (CacheHit),
    .err      (err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Backing memory, word addressed, and the reference cache directory.
  logic [15:0] bmem [32768];
  bit          ref_valid [32];
  logic [7:0]  ref_tag   [32];

  // Responder state.
  int          mem_delay   = 1;
  bit          expect_fill = 1'b0;
  bit          pend        = 1'b0;
  bit          orphan      = 1'b0;
  int          pend_cnt    = 0;
  logic [15:0] pend_addr   = 16'h0;
  logic [15:0] req_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory answers each request mem_delay cycles later; requests cut off by reset
  // still answer, which the controller must ignore.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (pend) begin
      if (rst) orphan = 1'b1;
      if (!orphan) check_eq("mem_addr_stable", mem_addr, pend_addr);
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_valid = 1'b1;
        mem_rdata = bmem[pend_addr[15:1]];
        pend      = 1'b0;
      end
    end
    if (mem_req) begin
      check_eq("one_outstanding", pend, 0);
      check_eq("req_expected", expect_fill, 1);
      pend      = 1'b1;
      orphan    = 1'b0;
      pend_cnt  = mem_delay;
      pend_addr = mem_addr;
      req_q.push_back(mem_addr);
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dout"}, DataOut, 0);
    check_eq({tag, "_done"}, Done, 0);
    check_eq({tag, "_stall"}, Stall, 0);
    check_eq({tag, "_hit"}, CacheHit, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_mreq"}, mem_req, 0);
    check_eq({tag, "_maddr"}, mem_addr, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_access(input logic [15:0] a, input logic rd, input logic wr, input int d);
    logic [7:0]  tg;
    logic [4:0]  idx;
    logic [15:0] fa;
    bit          is_err;
    bit          is_hit;
    int          cyc;
    tg        = a[15:8];
    idx       = a[7:3];
    mem_delay = d;
    @(negedge clk);
    Addr = a;
    Rd   = rd;
    Wr   = wr;
    #1;
    is_err = wr || (rd && a[0]);
    is_hit = rd && !is_err && ref_valid[idx] && (ref_tag[idx] == tg);
    check_eq("err", err, is_err);
    if (is_err || !rd) begin
      check_eq("noacc_done", Done, 0);
      check_eq("noacc_stall", Stall, 0);
      check_eq("noacc_dout", DataOut, 0);
    end else if (is_hit) begin
      check_eq("hit_done", Done, 1);
      check_eq("hit_flag", CacheHit, 1);
      check_eq("hit_stall", Stall, 0);
      check_eq("hit_data", DataOut, bmem[a[15:1]]);
    end else begin
      check_eq("miss_stall", Stall, 1);
      check_eq("miss_done", Done, 0);
      req_q.delete();
      expect_fill    = 1'b1;
      ref_valid[idx] = 1'b0;
      cyc            = 0;
      // Inputs are scrambled during the fill; the controller must ignore them.
      do begin
        @(negedge clk);
        Addr = 16'($urandom);
        Rd   = 1'($urandom);
        Wr   = 1'($urandom);
        #1;
        cyc++;
        if (!Done) begin
          check_eq("fill_stall", Stall, 1);
          check_eq("fill_err", err, 0);
        end
      end while (!Done && cyc < 400);
      check_eq("fill_latency", cyc, 4 * (d + 1) + 1);
      check_eq("fill_data", DataOut, bmem[a[15:1]]);
      check_eq("fill_hitflag", CacheHit, 0);
      check_eq("fill_done_stall", Stall, 0);
      check_eq("fill_nreq", req_q.size(), 4);
      for (int k = 0; k < 4 && k < req_q.size(); k++) begin
        fa = {tg, idx, 2'(k), 1'b0};
        check_eq("fill_addr", req_q[k], fa);
      end
      expect_fill    = 1'b0;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Rd   = 1'b0;
      Wr   = 1'b0;
      Addr = 16'($urandom);
      #1;
      check_eq("idle_done", Done, 0);
      check_eq("idle_stall", Stall, 0);
      check_eq("idle_mreq", mem_req, 0);
      check_eq("idle_dout", DataOut, 0);
    end
  endtask

  task automatic reset_mid_fill();
    mem_delay = 3;
    @(negedge clk);
    Addr = 16'h0040;
    Rd   = 1'b1;
    Wr   = 1'b0;
    #1;
    check_eq("rmf_stall", Stall, 1);
    expect_fill = 1'b1;
    // Miss, REQ, 3 x WAIT, REQ, then into the second WAIT.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Rd = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rmf_rst");
    @(negedge clk);
    #2;
    rst = 1'b0;
    expect_fill = 1'b0;
    model_reset();
    #1;
    check_all_zero("rmf_post");
    do_access(16'h0040, 1'b1, 1'b0, 1);
  endtask

  initial begin
    logic [15:0] a;
    logic        rd;
    logic        wr;
    rst       = 1'b1;
    Addr      = 16'h0;
    Rd        = 1'b0;
    Wr        = 1'b0;
    mem_valid = 1'b0;
    mem_rdata = 16'h0;
    for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      bmem[k]        = 16'h1000 + 16'(k);
      bmem[16'h80+k] = 16'h2000 + 16'(k);
    end
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("post_reset");

    do_access(16'h0000, 1'b1, 1'b0, 1);   // cold miss
    do_access(16'h0004, 1'b1, 1'b0, 1);   // hit after fill
    do_access(16'h0100, 1'b1, 1'b0, 1);   // conflict eviction
    do_access(16'h0000, 1'b1, 1'b0, 1);   // evicted line refills
    do_access(16'h0003, 1'b1, 1'b0, 1);   // misaligned read
    do_access(16'h0000, 1'b0, 1'b1, 1);   // write attempt
    reset_mid_fill();
    idle_cycles(20);
    do_access(16'h1236, 1'b1, 1'b0, 3);   // slow memory
    do_access(16'h1230, 1'b1, 1'b0, 3);

    for (int it = 0; it < 300; it++) begin
      a  = {6'($urandom_range(0, 3)), 10'($urandom)};
      a  = {a[15:1], ($urandom_range(0, 7) == 0)};
      a  = {a[15:14] == 2'b00 ? 8'(a[9:8]) : 8'(a[9:8]) , a[7:0]};
      rd = ($urandom_range(0, 9) != 0);
      wr = ($urandom_range(0, 9) == 0);
      do_access(a, rd, wr, $urandom_range(1, 4));
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
